load_hazard_ctrl: RTL

Load-side counterpart of the store-data forwarding logic in the 5-stage pipeline. It detects load-use hazards between a load in EX and the consuming instruction in ID, inserts exactly one bubble, and holds the whole pipeline while a multi-cycle data-memory read is outstanding in MEM. It also records hazard statistics and flags memory timeouts. It sits beside the ID/EX register and drives the stall and flush controls of the PC, IF/ID and ID/EX registers.

---
 rtl/load_hazard_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/load_hazard_ctrl.sv
// Load-use bubble insertion and multi-cycle data-memory hold for the 5-stage pipeline.
// Stall/flush/hold are combinational from registered state; lu_active, stall_cnt and err_timeout are registered.
module load_hazard_ctrl #(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             ex_memrd,
  input  logic [4:0]       ex_rt,
  input  logic             mem_memrd,
  input  logic             dmem_ready,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             idex_flush,
  output logic             pipe_hold,
  output logic             lu_active,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             err_timeout
);

  localparam int                WAIT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    LU_BUBBLE = 2'd1,
    MEM_WAIT  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              lu_active_q, lu_active_d;
  logic              err_q, err_d;

  logic hazard;
  logic mem_wait;
  logic stall_c;
  logic flush_c;
  logic hold_c;

  // Register 0 is hard-wired, so a load targeting it never creates a dependency.
  assign hazard = ex_memrd && (ex_rt != 5'd0) &&
                  ((id_use_rs && (id_rs == ex_rt)) || (id_use_rt && (id_rt == ex_rt)));

  assign mem_wait = mem_memrd && !dmem_ready;

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    stall_c = 1'b0;
    flush_c = 1'b0;
    hold_c  = 1'b0;
    case (state_q)
      RUN, LU_BUBBLE: begin
        if (mem_wait) begin
          stall_c = 1'b1;
          hold_c  = 1'b1;
          wait_d  = WAIT_W'(1);
          state_d = MEM_WAIT;
        end else if (hazard && (state_q == RUN)) begin
          // EX holds the bubble while in LU_BUBBLE, so only RUN can see a real hazard.
          stall_c = 1'b1;
          flush_c = 1'b1;
          wait_d  = '0;
          state_d = LU_BUBBLE;
        end else begin
          wait_d  = '0;
          state_d = RUN;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          wait_d  = '0;
          state_d = RUN;
        end else begin
          stall_c = 1'b1;
          hold_c  = 1'b1;
          wait_d  = (wait_q == WAIT_MAX) ? wait_q : wait_q + WAIT_W'(1);
        end
      end
      default: begin
        wait_d  = '0;
        state_d = RUN;
      end
    endcase
  end

  always_comb begin
    lu_active_d = (state_d == LU_BUBBLE);
    err_d       = err_q || (wait_d == WAIT_MAX);
    stall_cnt_d = stall_cnt_q;
    if (stall_c && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      wait_q      <= '0;
      stall_cnt_q <= '0;
      lu_active_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      stall_cnt_q <= stall_cnt_d;
      lu_active_q <= lu_active_d;
      err_q       <= err_d;
    end
  end

  // Gating with rst_n lets an in-flight stall drop the moment reset is asserted.
  assign pc_stall    = stall_c && rst_n;
  assign ifid_stall  = stall_c && rst_n;
  assign idex_flush  = flush_c && rst_n;
  assign pipe_hold   = hold_c  && rst_n;
  assign lu_active   = lu_active_q;
  assign stall_cnt   = stall_cnt_q;
  assign err_timeout = err_q;

endmodule
